// File: rtl/sync_filter_bit.sv
// rtl/sync_filter_bit.sv - one channel: flop synchronizer, optional stability filter, edge pulses.
// A level must be seen on FILTER_LEN consecutive synchronized samples before data_out follows it.
module sync_filter_bit #(
    parameter int   STAGES     = 2,
    parameter int   FILTER_LEN = 0,
    parameter logic RST_BIT    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    output logic data_out,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              y;
    logic              dly_q;

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_filter_bit: STAGES must be at least 2");
    end

    // Pure flop chain: nothing may sit between the metastability-settling stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_BIT}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], data_in};
        end
    end

    assign y = sync_q[STAGES-1];

    if (FILTER_LEN == 0) begin : g_bypass
        assign data_out = y;
    end else begin : g_filter
        localparam int               CNT_W    = $clog2(FILTER_LEN + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             out_q;
        logic             out_d;

        always_comb begin
            cnt_d = cnt_q;
            out_d = out_q;
            if (y == out_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                out_d = y;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                out_q <= RST_BIT;
            end else begin
                cnt_q <= cnt_d;
                out_q <= out_d;
            end
        end

        assign data_out = out_q;
    end

    // dly shares the reset value with data_out, so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q <= RST_BIT;
        end else begin
            dly_q <= data_out;
        end
    end

    assign rise = data_out & ~dly_q;
    assign fall = ~data_out & dly_q;

endmodule

// File: rtl/sync_filter_edge.sv
// rtl/sync_filter_edge.sv - multi-channel pad input conditioner with per-channel sync, filter and edges.
// Channels are fully independent; each gets its own reset level from RESET_VAL.
module sync_filter_edge #(
    parameter int               WIDTH      = 3,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 0,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_filter_edge: WIDTH must be at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_filter_bit #(
            .STAGES     (STAGES),
            .FILTER_LEN (FILTER_LEN),
            .RST_BIT    (RESET_VAL[i])
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .data_in  (data_in[i]),
            .data_out (data_out[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

endmodule

// File: tb/tb_sync_filter_edge.sv
// tb/tb_sync_filter_edge.sv - directed and random checks of sync_filter_edge against a sample-history model.
module tb_sync_filter_edge;
    localparam int         NI      = 6;
    localparam int         ST [NI] = '{2, 2, 2, 3, 2, 3};
    localparam int         NF [NI] = '{0, 0, 3, 0, 1, 2};
    localparam logic [2:0] RV [NI] = '{3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    localparam int         HMAX    = 4096;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic [2:0] data_in = 3'b000;
    logic [2:0] dout   [NI];
    logic [2:0] rise_w [NI];
    logic [2:0] fall_w [NI];

    int checks = 0;
    int errors = 0;

    logic [2:0] hist [HMAX];
    int         hcnt = 0;
    logic [2:0] exp_out  [NI];
    logic [2:0] exp_prev [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sync_filter_edge #(
            .WIDTH      (3),
            .STAGES     (ST[g]),
            .FILTER_LEN (NF[g]),
            .RESET_VAL  (RV[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .data_in  (data_in),
            .data_out (dout[g]),
            .rise     (rise_w[g]),
            .fall     (fall_w[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Synchronized level visible after edge m: the input sampled STAGES-1 edges earlier.
    function automatic logic [2:0] yv(input int m, input int s, input logic [2:0] r);
        int idx;
        idx = m - s;
        if (idx >= 0 && idx < HMAX) return hist[idx];
        return r;
    endfunction

    task automatic model_edge();
        logic [2:0] yw;
        logic       v;
        bit         ok;
        if (rst) begin
            hcnt = 0;
            for (int i = 0; i < NI; i++) begin
                exp_out[i]  = RV[i];
                exp_prev[i] = RV[i];
            end
        end else begin
            if (hcnt < HMAX) hist[hcnt] = data_in;
            hcnt++;
            for (int i = 0; i < NI; i++) begin
                exp_prev[i] = exp_out[i];
                if (NF[i] == 0) begin
                    exp_out[i] = yv(hcnt, ST[i], RV[i]);
                end else begin
                    for (int c = 0; c < 3; c++) begin
                        v  = ~exp_prev[i][c];
                        ok = 1'b1;
                        for (int j = 0; j < NF[i]; j++) begin
                            yw = yv(hcnt - 1 - j, ST[i], RV[i]);
                            if (yw[c] !== v) ok = 1'b0;
                        end
                        if (ok) exp_out[i][c] = v;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("model_dout_u%0d", i), 32'(dout[i]), 32'(exp_out[i]));
            chk($sformatf("model_rise_u%0d", i), 32'(rise_w[i]), 32'(exp_out[i] & ~exp_prev[i]));
            chk($sformatf("model_fall_u%0d", i), 32'(fall_w[i]), 32'(~exp_out[i] & exp_prev[i]));
        end
    endtask

    task automatic drive(input logic [2:0] d);
        @(negedge clk);
        data_in = d;
    endtask

    task automatic set_rst(input logic r);
        @(negedge clk);
        rst = r;
    endtask

    task automatic settle(input logic [2:0] d, input int n);
        drive(d);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int nr;
        int nf;

        // Asynchronous reset before any clock edge.
        #3;
        data_in = 3'b101;
        rst     = 1'b1;
        #1;
        chk("async_rst_u0_dout", 32'(dout[0]), 32'h5);
        chk("async_rst_u1_dout", 32'(dout[1]), 32'h0);
        chk("async_rst_u0_rise", 32'(rise_w[0]), 32'h0);
        tick();
        tick();
        set_rst(1'b0);
        for (int e = 0; e < 5; e++) begin
            tick();
            chk("rstval_no_rise", 32'(rise_w[0]), 32'h0);
            chk("rstval_no_fall", 32'(fall_w[0]), 32'h0);
            chk("rstval_dout", 32'(dout[0]), 32'h5);
        end

        // Bypass latency on a zero-reset instance.
        settle(3'b000, 4);
        drive(3'b001);
        tick();
        chk("byp_e1_dout", 32'(dout[1]), 32'h0);
        chk("byp_e1_rise", 32'(rise_w[1]), 32'h0);
        tick();
        chk("byp_e2_dout", 32'(dout[1]), 32'h1);
        chk("byp_e2_rise", 32'(rise_w[1]), 32'h1);
        tick();
        chk("byp_e3_dout", 32'(dout[1]), 32'h1);
        chk("byp_e3_rise", 32'(rise_w[1]), 32'h0);

        // Filter pass: three sampled highs propagate on edge 5, return on edge 8.
        settle(3'b000, 8);
        nr = 0;
        nf = 0;
        for (int e = 1; e <= 12; e++) begin
            if (e == 1) drive(3'b010);
            else if (e == 4) drive(3'b000);
            tick();
            chk($sformatf("flt_pass_lvl_e%0d", e), 32'(dout[2][1]), 32'((e >= 5 && e <= 7) ? 1 : 0));
            nr += int'(rise_w[2][1]);
            nf += int'(fall_w[2][1]);
        end
        chk("flt_pass_rise_cnt", 32'(nr), 32'd1);
        chk("flt_pass_fall_cnt", 32'(nf), 32'd1);

        // Glitch rejection: two sampled highs, then alternating single-cycle pulses.
        settle(3'b000, 6);
        for (int e = 1; e <= 12; e++) begin
            if (e == 1) drive(3'b010);
            else if (e == 3) drive(3'b000);
            tick();
            chk("glitch2_lvl", 32'(dout[2][1]), 32'h0);
            chk("glitch2_edges", 32'({rise_w[2][1], fall_w[2][1]}), 32'h0);
        end
        for (int e = 0; e < 20; e++) begin
            drive((e % 2 == 0) ? 3'b010 : 3'b000);
            tick();
            chk("glitch_alt_lvl", 32'(dout[2][1]), 32'h0);
            chk("glitch_alt_edges", 32'({rise_w[2][1], fall_w[2][1]}), 32'h0);
        end
        settle(3'b000, 4);

        // Reset while the filter counter is part-way.
        settle(3'b000, 6);
        drive(3'b100);
        tick();
        tick();
        tick();
        set_rst(1'b1);
        tick();
        tick();
        set_rst(1'b0);
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("midrst_lvl_e%0d", e), 32'(dout[2][2]), 32'((e >= 5) ? 1 : 0));
            chk($sformatf("midrst_rise_e%0d", e), 32'(rise_w[2][2]), 32'((e == 5) ? 1 : 0));
        end

        // Multi-channel, three-stage synchronizer.
        settle(3'b000, 8);
        drive(3'b111);
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("mc_up_dout_e%0d", e), 32'(dout[3]), 32'((e >= 3) ? 3'b111 : 3'b000));
            chk($sformatf("mc_up_rise_e%0d", e), 32'(rise_w[3]), 32'((e == 3) ? 3'b111 : 3'b000));
        end
        tick();
        tick();
        drive(3'b010);
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("mc_dn_dout_e%0d", e), 32'(dout[3]), 32'((e >= 3) ? 3'b010 : 3'b111));
            chk($sformatf("mc_dn_fall_e%0d", e), 32'(fall_w[3]), 32'((e == 3) ? 3'b101 : 3'b000));
            chk($sformatf("mc_dn_rise_e%0d", e), 32'(rise_w[3]), 32'h0);
        end

        // Random bit flips with occasional resets, checked only against the model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 3) == 0) data_in[c] = ~data_in[c];
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_filter_edge.md
Name: sync_filter_edge

Overview:
- Parametrised multi-channel input conditioner for asynchronous pad signals (SPI nCS/COPI/SCLK and similar).
- Per channel: N-stage flip-flop synchronizer, optional glitch filter on consecutive stable samples, and one-cycle rise/fall pulses.
- Sits between top-level `ui_in` pins and protocol logic such as the SPI peripheral.
- Replaces the fixed 2-stage, 3-signal synchronizer with depth, width, filtering and edge detection chosen per instance.

Parameters:
- WIDTH, 3: number of independent channels; must be ≥1.
- STAGES, 2: synchronizer flops per channel; must be ≥2 (elaboration error otherwise).
- FILTER_LEN, 0: consecutive-sample count before `data_out` may change. 0 = filter bypassed.
- RESET_VAL, {WIDTH{1'b0}}: per-channel reset value of every sync flop, `data_out`, and the internal delayed copy.

Ports:
- clk  input  1  system clock (10 MHz); every flop samples on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- data_in  input  WIDTH  raw asynchronous inputs.
- data_out  output  WIDTH  synchronized, filtered level.
- rise  output  WIDTH  one-cycle pulse on 0→1 transition of `data_out[i]`.
- fall  output  WIDTH  one-cycle pulse on 1→0 transition of `data_out[i]`.

Behaviour:
- **Reset**
  - `rst` high clears state immediately, with no clock needed.
  - Sync flops, `data_out` and `dly` load RESET_VAL; filter counters load 0.
  - `rise` and `fall` read 0 during reset and in the first cycle after it; RESET_VAL therefore produces no spurious edge.
- **Synchronizer**
  - Per channel, shift chain s[0..STAGES-1], with s[0] <= data_in[i].
  - Synchronized value is y = s[STAGES-1].
  - No logic is allowed between chain flops.
- **FILTER_LEN = 0**
  - `data_out` = y, with no extra register.
  - Latency is STAGES rising edges from the first edge that samples the new input.
- **FILTER_LEN = N ≥ 1**
  - Per-channel counter cnt, width $clog2(N+1), with `data_out` held in a register.
  - Each edge:
    - If y == data_out: cnt <= 0.
    - Else if cnt == N-1: data_out <= y and cnt <= 0.
    - Else: cnt <= cnt+1.
  - Latency: `data_out` changes on edge STAGES+N, counting the first sampling edge as edge 1.
  - An input level held for ≥N sampled cycles always propagates.
  - An input level held for ≤N-1 sampled cycles is rejected: cnt returns to 0 and `data_out` does not toggle.
  - The counter never exceeds N-1 and does not wrap.
- **Edge detect**
  - `dly` <= data_out on every edge.
  - rise = data_out & ~dly; fall = ~data_out & dly.
  - Each pulse is high exactly one cycle, in the same cycle `data_out` first shows the new level.
  - rise and fall are never both high on one channel.
- **Channels** are fully independent: simultaneous changes on several channels produce simultaneous, independent pulses.
- **Reset mid-filter** (cnt non-zero) discards partial counts; after release, filtering restarts from cnt=0.

Decomposition:
- No shared package is needed.
- One sub-module, `sync_filter_bit`: a single channel with parameters STAGES, FILTER_LEN and RST_BIT, instantiated WIDTH times via generate.
- The counter width is a localparam inside `sync_filter_bit`.
- Edge detection lives in `sync_filter_bit`.

Test Plan:
- **Reset (WIDTH=3, STAGES=2, FILTER_LEN=0, RESET_VAL=3'b101):**
  - Assert rst mid-cycle, no clock → data_out=3'b101 immediately.
  - Release rst with data_in=3'b101 → rise=fall=0 for 5 cycles.
- **Bypass latency (same config, RESET_VAL=0):**
  - data_in[0] 0→1 before edge 1 → data_out[0]=1 after edge 2.
  - rise[0]=1 for exactly the cycle after edge 2 (same cycle data_out rises).
- **Filter pass (STAGES=2, FILTER_LEN=3):**
  - data_in[1] high for 3 sampled cycles then low → data_out[1]=1 after edge 5, back to 0 after edge 8.
  - Exactly one rise and one fall pulse.
- **Glitch reject (same config):**
  - data_in[1] high for exactly 2 sampled cycles → data_out[1] stays 0; rise/fall never assert.
  - Repeat with 1-cycle pulses every other cycle for 20 cycles → no output change.
- **Mid-operation reset (same config):**
  - Raise data_in[2], assert rst after edge 3 (cnt=1), hold input high, release rst.
  - → data_out[2] rises STAGES+3 edges after release, never earlier.
- **Multi-channel, STAGES=3:**
  - data_in 3'b000→3'b111 on one edge → all three rise bits pulse together after edge 3.
  - Then 3'b111→3'b010 → fall[2] and fall[0] pulse together; channel 1 shows no pulse.
